priority_decoder: RTL and testbench

Sequential decoder for the 7-request priority encoding scheme: accepts a stream of 3-bit request codes (0 = no request, 1..7 = winning request index) through a valid/ready handshake, buffers them, and replays each as a one-hot `grant[7:1]` pulse of fixed width. Sits downstream of the priority encoder, turning its encoded winner back into a per-requester grant line. Maintains a saturating count of grants issued for lab-bench checking.

---
 rtl/priority_pkg.sv | 26 ++
 rtl/priority_decoder_if.sv | 22 ++
 rtl/code_fifo.sv | 53 +++++
 rtl/priority_decoder.sv | 95 +++++++++
 tb/tb_priority_decoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/priority_pkg.sv
// Shared types, widths and the code-to-grant helper for the priority decoder.
package priority_pkg;

   localparam int unsigned NUM_REQ = 7;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned COUNT_W = 16;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } dec_state_t;

   // Code k maps to grant bit k; code 0 maps to no grant.
   function automatic logic [NUM_REQ:1] onehot7(input code_t code);
      logic [NUM_REQ:1] v;
      v = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         v[k] = (code == CODE_W'(k));
      end
      return v;
   endfunction

endpackage

// File: rtl/priority_decoder_if.sv
// Code-stream and grant bundle between the priority encoder side and the decoder.
interface priority_decoder_if;
   import priority_pkg::*;

   logic                 in_valid;
   code_t                in_code;
   logic                 in_ready;
   logic [NUM_REQ:1]     grant;
   logic                 busy;
   logic [COUNT_W-1:0]   grant_count;

   modport master (
      output in_valid, in_code,
      input  in_ready, grant, busy, grant_count
   );

   modport slave (
      input  in_valid, in_code,
      output in_ready, grant, busy, grant_count
   );

endinterface

// File: rtl/code_fifo.sv
// Synchronous FIFO with occupancy count; push is allowed at full when a pop frees a slot.
module code_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/priority_decoder.sv
// Replays queued priority codes as fixed-width one-hot grant pulses with a saturating grant count.
module priority_decoder
   import priority_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned DEPTH       = 4
) (
   input  logic               clk,
   input  logic               reset,
   priority_decoder_if.slave  bus
);

   localparam int unsigned HOLD_W = 4;

   dec_state_t          r_state;
   dec_state_t          w_next_state;
   logic [HOLD_W-1:0]   r_hold;
   logic [NUM_REQ:1]    r_grant;
   logic [COUNT_W-1:0]  r_grant_count;
   logic                r_busy;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   code_t               w_head;

   // Code 0 completes the handshake but never enters the queue.
   assign bus.in_ready    = !w_full && !reset;
   assign w_push          = bus.in_valid && bus.in_ready && (bus.in_code != '0);
   assign bus.grant       = r_grant;
   assign bus.busy        = r_busy;
   assign bus.grant_count = r_grant_count;

   code_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (bus.in_code),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = GRANT;
            end
         end
         GRANT:   if (r_hold == '0) w_next_state = GAP;
         GAP:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Busy looks one state ahead so it tracks the FSM as a registered flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold  <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_busy <= (w_next_state != IDLE) || !w_empty;
         if (w_pop) begin
            r_grant <= onehot7(w_head);
            r_hold  <= HOLD_W'(HOLD_CYCLES - 1);
         end else if (r_state == GRANT) begin
            if (r_hold == '0) r_grant <= '0;
            else              r_hold  <= r_hold - HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant_count <= '0;
      end else if (w_pop && (r_grant_count != '1)) begin
         r_grant_count <= r_grant_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed scoreboard bench for priority_decoder: grant order, pulse/gap timing, queue limits, reset, saturation.
module tb_priority_decoder;
   import priority_pkg::*;

   localparam int unsigned HOLD = 4;
   localparam int unsigned DEP  = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   priority_decoder_if bus ();

   priority_decoder #(
      .HOLD_CYCLES (HOLD),
      .DEPTH       (DEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic [7:1]  exp_q [$];
   int          rise_q [$];
   logic [7:1]  prev_g   = '0;
   int          width    = 0;
   int          zero_run = 0;
   bit          backlog  = 1'b0;

   function automatic logic [7:1] exp_oh(input logic [2:0] code);
      logic [7:1] v;
      v = '0;
      if (code != 3'd0) v = 7'(7'd1 << (int'(code) - 1));
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
   endtask

   // One clock: record accepted codes, advance, then watch the grant line.
   task automatic tick();
      logic       rst_edge;
      logic [7:1] g;
      logic [7:1] e;
      rst_edge = reset;
      if (bus.in_valid && bus.in_ready && bus.in_code != 3'd0)
         exp_q.push_back(exp_oh(bus.in_code));
      @(posedge clk);
      #1;
      cyc++;
      g = bus.grant;
      if (rst_edge) begin
         exp_q.delete();
         rise_q.delete();
         prev_g   = '0;
         width    = 0;
         zero_run = 0;
         backlog  = 1'b0;
      end else begin
         if (g != '0 && prev_g == '0) begin
            if (backlog) check("gap_len", 32'(zero_run), 32'(2));
            if (exp_q.size() == 0) begin
               check("unexpected_grant", 32'(g), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("grant_order", 32'(g), 32'(e));
            end
            width = 1;
            rise_q.push_back(cyc);
         end else if (g != '0) begin
            check("grant_stable", 32'(g), 32'(prev_g));
            width++;
         end else if (prev_g != '0) begin
            check("pulse_width", 32'(width), 32'(HOLD));
            zero_run = 1;
            backlog  = (exp_q.size() != 0);
         end else begin
            zero_run++;
         end
         prev_g = g;
      end
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_code  = 3'd0;
      #1;
      check("rst_ready_low", 32'(bus.in_ready), 32'(0));
      tick();
      reset = 1'b0;
      #1;
      check("rst_grant", 32'(bus.grant), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_count", 32'(bus.grant_count), 32'(0));
      check("rst_ready_high", 32'(bus.in_ready), 32'(1));
   endtask

   task automatic send(input logic [2:0] code);
      int budget;
      budget       = 100;
      bus.in_valid = 1'b1;
      bus.in_code  = code;
      while (!bus.in_ready && budget > 0) begin
         tick();
         budget--;
      end
      check("send_timeout", 32'(budget > 0), 32'(1));
      tick();
      bus.in_valid = 1'b0;
      bus.in_code  = 3'd0;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget       = 300;
      bus.in_valid = 1'b0;
      while ((bus.busy || bus.grant != '0 || exp_q.size() != 0) && budget > 0) begin
         tick();
         budget--;
      end
      check({tag, "_drain_timeout"}, 32'(budget > 0), 32'(1));
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] full_codes [6];
      logic [2:0] burst      [4];
      full_codes = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd7, 3'd3};
      burst      = '{3'd7, 3'd1, 3'd0, 3'd3};
      bus.in_valid = 1'b0;
      bus.in_code  = 3'd0;

      // Single code accepted at edge 10.
      do_reset();
      while (cyc < 9) tick();
      send(3'd5);
      check("single_busy_e10", 32'(bus.busy), 32'(0));
      for (int e = 11; e <= 14; e++) begin
         tick();
         check("single_grant_high", 32'(bus.grant), 32'(7'b0010000));
         check("single_busy_high", 32'(bus.busy), 32'(1));
      end
      tick();
      check("single_grant_fall_e15", 32'(bus.grant), 32'(0));
      check("single_busy_gap", 32'(bus.busy), 32'(1));
      tick();
      check("single_busy_e16", 32'(bus.busy), 32'(0));
      check("single_count", 32'(bus.grant_count), 32'(1));

      // Burst including a code 0.
      do_reset();
      for (int i = 0; i < 4; i++) send(burst[i]);
      drain("burst");
      check("burst_count", 32'(bus.grant_count), 32'(3));
      check("burst_rises", 32'(rise_q.size()), 32'(3));
      if (rise_q.size() == 3) begin
         check("burst_period0", 32'(rise_q[1] - rise_q[0]), 32'(HOLD + 2));
         check("burst_period1", 32'(rise_q[2] - rise_q[1]), 32'(HOLD + 2));
      end

      // Full queue backpressure.
      do_reset();
      while (cyc < 19) tick();
      for (int i = 0; i < 5; i++) send(full_codes[i]);
      check("full_ready_low", 32'(bus.in_ready), 32'(0));
      send(full_codes[5]);
      drain("full");
      check("full_count", 32'(bus.grant_count), 32'(6));

      // Reset during the second grant cycle of code 3.
      do_reset();
      send(3'd3);
      send(3'd5);
      tick();
      check("midrst_grant_before", 32'(bus.grant), 32'(7'b0000100));
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      check("midrst_grant_idle", 32'(bus.grant), 32'(0));
      check("midrst_count", 32'(bus.grant_count), 32'(0));
      check("midrst_busy", 32'(bus.busy), 32'(0));

      // Pointer wrap-around with ten codes.
      do_reset();
      for (int i = 0; i < 10; i++) send(3'((i % 7) + 1));
      drain("wrap");
      check("wrap_count", 32'(bus.grant_count), 32'(10));
      check("wrap_rises", 32'(rise_q.size()), 32'(10));

      // Saturation of the grant counter.
      do_reset();
      tick();
      force dut.r_grant_count = 16'hFFFE;
      #1;
      release dut.r_grant_count;
      #1;
      check("sat_preload", 32'(bus.grant_count), 32'(16'hFFFE));
      send(3'd6);
      drain("sat1");
      check("sat_reach", 32'(bus.grant_count), 32'(16'hFFFF));
      send(3'd6);
      drain("sat2");
      check("sat_hold", 32'(bus.grant_count), 32'(16'hFFFF));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
